daq_conv_sequencer: RTL

Parametrised conversion-trigger sequencer for the DAQ front end. It drives active-low CONVST pulses to N_ADC converters with runtime-programmable period and pulse width, and waits on the per-ADC BUSY lines before each trigger. It supports finite bursts, continuous mode, a BUSY timeout with abort, and a conversion counter. It sits between the host register block, which supplies configuration and start, and the ADC pins.

---
 rtl/daq_pkg.sv | 27 ++
 rtl/daq_conv_sequencer_if.sv | 47 ++++
 rtl/daq_tick_counter.sv | 34 +++
 rtl/daq_conv_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// daq_pkg: shared definitions for the DAQ conversion-trigger sequencer and
// the host register block.
//   - daq_state_e : sequencer state encoding (also visible on the debug port)
//   - DAQ_*       : default widths / converter count
//   - max3        : helper used to size the shared tick counter
package daq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PERIOD    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_TRIGGER   = 2'd3
    } daq_state_e;

    localparam int DAQ_N_ADC     = 2;
    localparam int DAQ_PERIOD_W  = 16;
    localparam int DAQ_PULSE_W   = 8;
    localparam int DAQ_TIMEOUT_W = 12;
    localparam int DAQ_CNT_W     = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/daq_conv_sequencer_if.sv
// daq_conv_sequencer_if: host configuration, ADC pin and status signals of
// the conversion sequencer, bundled as one interface.
//   slave  modport : the sequencer (config/busy in, CONVST/status out)
//   master modport : the environment (register block + ADC pins)
// Handshake: start_i is a single-cycle request sampled on the rising edge;
// it is accepted only in IDLE with en_i=1 and a non-zero adc_mask_i, and the
// acceptance is visible as active_o rising in the following cycle.
// state_o is a debug view of the sequencer state register.
interface daq_conv_sequencer_if
    import daq_pkg::*;
#(
    parameter int N_ADC     = DAQ_N_ADC,
    parameter int PERIOD_W  = DAQ_PERIOD_W,
    parameter int PULSE_W   = DAQ_PULSE_W,
    parameter int TIMEOUT_W = DAQ_TIMEOUT_W,
    parameter int CNT_W     = DAQ_CNT_W
) ();
    logic                 en_i;
    logic                 start_i;
    logic [PERIOD_W-1:0]  period_i;
    logic [PULSE_W-1:0]   pulse_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [CNT_W-1:0]     burst_i;
    logic [N_ADC-1:0]     adc_mask_i;
    logic [N_ADC-1:0]     busy_i;
    logic [N_ADC-1:0]     conv_clk_o;
    logic                 active_o;
    logic                 done_o;
    logic                 timeout_o;
    logic                 err_o;
    logic [CNT_W-1:0]     conv_count_o;
    daq_state_e           state_o;

    modport slave (
        input  en_i, start_i, period_i, pulse_i, timeout_i, burst_i,
               adc_mask_i, busy_i,
        output conv_clk_o, active_o, done_o, timeout_o, err_o,
               conv_count_o, state_o
    );

    modport master (
        output en_i, start_i, period_i, pulse_i, timeout_i, burst_i,
               adc_mask_i, busy_i,
        input  conv_clk_o, active_o, done_o, timeout_o, err_o,
               conv_count_o, state_o
    );
endinterface

// File: rtl/daq_tick_counter.sv
// daq_tick_counter: loadable down-counter timing one sequencer state.
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : load load_val_i (0 loads as 1) for the state being entered
//   load_val_i     : length of that state in cycles
//   last_o         : high in the final cycle of the loaded interval
// The count saturates at 1 so last_o stays high once reached; this keeps a
// disabled timeout (loaded as 1) harmless while waiting on BUSY.
module daq_tick_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? W'(1) : load_val_i;
        end else if (cnt_q > W'(1)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= W'(1);
        else         cnt_q <= cnt_d;
    end

    assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/daq_conv_sequencer.sv
// daq_conv_sequencer: issues active-low CONVST pulses to N_ADC converters.
//   clk_i, reset_i : clock, synchronous active-high reset (highest priority)
//   bus (slave)    : en/start/config/busy in; conv_clk_o, active_o, done_o,
//                    timeout_o, err_o, conv_count_o, state_o out
// Sequence: IDLE -> PERIOD -> [WAIT_BUSY] -> TRIGGER -> PERIOD ... until the
// burst count is reached (done_o), BUSY times out (timeout_o, err_o) or en_i
// drops (silent abort). All outputs are registered and decoded from the next
// state, so CONVST is low exactly while the state register holds TRIGGER.
module daq_conv_sequencer
    import daq_pkg::*;
#(
    parameter int N_ADC     = DAQ_N_ADC,
    parameter int PERIOD_W  = DAQ_PERIOD_W,
    parameter int PULSE_W   = DAQ_PULSE_W,
    parameter int TIMEOUT_W = DAQ_TIMEOUT_W,
    parameter int CNT_W     = DAQ_CNT_W
) (
    input logic                 clk_i,
    input logic                 reset_i,
    daq_conv_sequencer_if.slave bus
);
    // One counter times every state; period, pulse and timeout never overlap.
    localparam int TICK_W = max3(PERIOD_W, PULSE_W, TIMEOUT_W);

    daq_state_e           state_q, state_d;
    logic [PERIOD_W-1:0]  cfg_period_q, cfg_period_d;
    logic [PULSE_W-1:0]   cfg_pulse_q, cfg_pulse_d;
    logic [TIMEOUT_W-1:0] cfg_tmo_q, cfg_tmo_d;
    logic [CNT_W-1:0]     cfg_burst_q, cfg_burst_d;
    logic [N_ADC-1:0]     cfg_mask_q, cfg_mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_ADC-1:0]     conv_clk_q, conv_clk_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 err_q, err_d;

    logic              tick_load;
    logic [TICK_W-1:0] tick_val;
    logic              tick_last;
    logic              busy_hit;

    assign busy_hit = |(bus.busy_i & cfg_mask_q);

    always_comb begin
        state_d      = state_q;
        cfg_period_d = cfg_period_q;
        cfg_pulse_d  = cfg_pulse_q;
        cfg_tmo_d    = cfg_tmo_q;
        cfg_burst_d  = cfg_burst_q;
        cfg_mask_d   = cfg_mask_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        tmo_d        = 1'b0;
        err_d        = err_q;
        tick_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && bus.en_i && (bus.adc_mask_i != '0)) begin
                    cfg_period_d = bus.period_i;
                    cfg_pulse_d  = bus.pulse_i;
                    cfg_tmo_d    = bus.timeout_i;
                    cfg_burst_d  = bus.burst_i;
                    cfg_mask_d   = bus.adc_mask_i;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    state_d      = ST_PERIOD;
                    tick_val     = TICK_W'(bus.period_i);
                end
            end
            ST_PERIOD: begin
                if (tick_last) begin
                    if (busy_hit) begin
                        state_d  = ST_WAIT_BUSY;
                        tick_val = TICK_W'(cfg_tmo_q);
                    end else begin
                        state_d  = ST_TRIGGER;
                        tick_val = TICK_W'(cfg_pulse_q);
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT_BUSY: begin
                // BUSY clearing wins over a timeout expiring in the same cycle.
                if (!busy_hit) begin
                    state_d  = ST_TRIGGER;
                    tick_val = TICK_W'(cfg_pulse_q);
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if ((cfg_tmo_q != '0) && tick_last) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_TRIGGER: begin
                if (tick_last) begin
                    if ((cfg_burst_q != '0) && (cnt_q == cfg_burst_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_PERIOD;
                        tick_val = TICK_W'(cfg_period_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable aborts silently: no status pulses, counter and config held.
        if (!bus.en_i) begin
            state_d      = ST_IDLE;
            cfg_period_d = cfg_period_q;
            cfg_pulse_d  = cfg_pulse_q;
            cfg_tmo_d    = cfg_tmo_q;
            cfg_burst_d  = cfg_burst_q;
            cfg_mask_d   = cfg_mask_q;
            cnt_d        = cnt_q;
            done_d       = 1'b0;
            tmo_d        = 1'b0;
            err_d        = err_q;
            tick_val     = '0;
        end

        conv_clk_d = (state_d == ST_TRIGGER) ? ~cfg_mask_d : '1;
        active_d   = (state_d != ST_IDLE);
        tick_load  = (state_d != state_q) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cfg_period_q <= '0;
            cfg_pulse_q  <= '0;
            cfg_tmo_q    <= '0;
            cfg_burst_q  <= '0;
            cfg_mask_q   <= '0;
            cnt_q        <= '0;
            conv_clk_q   <= '1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_period_q <= cfg_period_d;
            cfg_pulse_q  <= cfg_pulse_d;
            cfg_tmo_q    <= cfg_tmo_d;
            cfg_burst_q  <= cfg_burst_d;
            cfg_mask_q   <= cfg_mask_d;
            cnt_q        <= cnt_d;
            conv_clk_q   <= conv_clk_d;
            active_q     <= active_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
        end
    end

    daq_tick_counter #(.W(TICK_W)) u_tick (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tick_load),
        .load_val_i (tick_val),
        .last_o     (tick_last)
    );

    assign bus.conv_clk_o   = conv_clk_q;
    assign bus.active_o     = active_q;
    assign bus.done_o       = done_q;
    assign bus.timeout_o    = tmo_q;
    assign bus.err_o        = err_q;
    assign bus.conv_count_o = cnt_q;
    assign bus.state_o      = state_q;
endmodule
